// File: rtl/median_pkg.sv
// Shared mode encoding and pipeline constants for the 3x3 rank filter.
// Imported by the compare-exchange cell and the pipeline top.
package median_pkg;

  typedef enum logic [1:0] {
    MODE_MED = 2'b00,
    MODE_MIN = 2'b01,
    MODE_MAX = 2'b10,
    MODE_CTR = 2'b11
  } mode_t;

  localparam int PIPE_LAT = 3;
  localparam int WIN_N    = 9;

endpackage

// File: rtl/mce_param.sv
// Combinational unsigned compare-exchange cell; ties keep lo=a, hi=b.
// Zero latency, no state.
module mce_param #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/median3x3_pipe.sv
// 3x3 window rank filter: median/min/max/centre per window, 3-cycle latency, 1 window/clk.
// No backpressure; data registers only load on their stage's valid so bubbles hold out_pix.
module median3x3_pipe
  import median_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [WIN_N*WIDTH-1:0] win,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_pix,
  output logic [1:0]             out_mode
);

  // Cell outputs that no stage consumes; the name keeps them out of lint reports.
  logic [7:0][WIDTH-1:0] unused_ce;

  logic [2:0][WIDTH-1:0] row_lo_d, row_mid_d, row_hi_d;

  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [WIDTH-1:0] l0, h0, l1;
    mce_param #(.WIDTH(WIDTH)) u_ce0 (
      .a(win[(3*r)*WIDTH +: WIDTH]), .b(win[(3*r+1)*WIDTH +: WIDTH]), .lo(l0), .hi(h0));
    mce_param #(.WIDTH(WIDTH)) u_ce1 (
      .a(h0), .b(win[(3*r+2)*WIDTH +: WIDTH]), .lo(l1), .hi(row_hi_d[r]));
    mce_param #(.WIDTH(WIDTH)) u_ce2 (
      .a(l0), .b(l1), .lo(row_lo_d[r]), .hi(row_mid_d[r]));
  end

  logic                  s1_vld_q;
  logic [2:0][WIDTH-1:0] s1_lo_q, s1_mid_q, s1_hi_q;
  logic [WIDTH-1:0]      s1_ctr_q;
  mode_t                 s1_mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_lo_q   <= '0;
      s1_mid_q  <= '0;
      s1_hi_q   <= '0;
      s1_ctr_q  <= '0;
      s1_mode_q <= MODE_MED;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_lo_q   <= row_lo_d;
        s1_mid_q  <= row_mid_d;
        s1_hi_q   <= row_hi_d;
        s1_ctr_q  <= win[4*WIDTH +: WIDTH];
        s1_mode_q <= mode_t'(mode);
      end
    end
  end

  logic [WIDTH-1:0] lo_a, lo_b, mid_a, mid_b, mid_c, hi_a, hi_b;
  logic [WIDTH-1:0] gmin_d, maxlo_d, medmid_d, minhi_d, gmax_d;

  mce_param #(.WIDTH(WIDTH)) u_lo0 (.a(s1_lo_q[0]), .b(s1_lo_q[1]), .lo(lo_a), .hi(lo_b));
  mce_param #(.WIDTH(WIDTH)) u_lo1 (.a(lo_a), .b(s1_lo_q[2]), .lo(gmin_d), .hi(unused_ce[0]));
  mce_param #(.WIDTH(WIDTH)) u_lo2 (.a(lo_b), .b(s1_lo_q[2]), .lo(unused_ce[1]), .hi(maxlo_d));

  mce_param #(.WIDTH(WIDTH)) u_md0 (.a(s1_mid_q[0]), .b(s1_mid_q[1]), .lo(mid_a), .hi(mid_b));
  mce_param #(.WIDTH(WIDTH)) u_md1 (.a(mid_b), .b(s1_mid_q[2]), .lo(mid_c), .hi(unused_ce[2]));
  mce_param #(.WIDTH(WIDTH)) u_md2 (.a(mid_a), .b(mid_c), .lo(unused_ce[3]), .hi(medmid_d));

  mce_param #(.WIDTH(WIDTH)) u_hi0 (.a(s1_hi_q[0]), .b(s1_hi_q[1]), .lo(hi_a), .hi(hi_b));
  mce_param #(.WIDTH(WIDTH)) u_hi1 (.a(hi_a), .b(s1_hi_q[2]), .lo(minhi_d), .hi(unused_ce[4]));
  mce_param #(.WIDTH(WIDTH)) u_hi2 (.a(hi_b), .b(s1_hi_q[2]), .lo(unused_ce[5]), .hi(gmax_d));

  logic             s2_vld_q;
  logic [WIDTH-1:0] s2_maxlo_q, s2_medmid_q, s2_minhi_q, s2_gmin_q, s2_gmax_q, s2_ctr_q;
  mode_t            s2_mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q    <= 1'b0;
      s2_maxlo_q  <= '0;
      s2_medmid_q <= '0;
      s2_minhi_q  <= '0;
      s2_gmin_q   <= '0;
      s2_gmax_q   <= '0;
      s2_ctr_q    <= '0;
      s2_mode_q   <= MODE_MED;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_maxlo_q  <= maxlo_d;
        s2_medmid_q <= medmid_d;
        s2_minhi_q  <= minhi_d;
        s2_gmin_q   <= gmin_d;
        s2_gmax_q   <= gmax_d;
        s2_ctr_q    <= s1_ctr_q;
        s2_mode_q   <= s1_mode_q;
      end
    end
  end

  logic [WIDTH-1:0] fm_a, fm_b, fm_c, med_d, pix_d;

  mce_param #(.WIDTH(WIDTH)) u_fm0 (.a(s2_maxlo_q), .b(s2_medmid_q), .lo(fm_a), .hi(fm_b));
  mce_param #(.WIDTH(WIDTH)) u_fm1 (.a(fm_b), .b(s2_minhi_q), .lo(fm_c), .hi(unused_ce[6]));
  mce_param #(.WIDTH(WIDTH)) u_fm2 (.a(fm_a), .b(fm_c), .lo(unused_ce[7]), .hi(med_d));

  always_comb begin
    pix_d = med_d;
    case (s2_mode_q)
      MODE_MIN: pix_d = s2_gmin_q;
      MODE_MAX: pix_d = s2_gmax_q;
      MODE_CTR: pix_d = s2_ctr_q;
      default:  pix_d = med_d;
    endcase
  end

  logic             out_vld_q;
  logic [WIDTH-1:0] out_pix_q;
  mode_t            out_mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_pix_q  <= '0;
      out_mode_q <= MODE_MED;
    end else begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_pix_q  <= pix_d;
        out_mode_q <= s2_mode_q;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_pix   = out_pix_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_median3x3_pipe.sv
// Drives an 8-bit and a 10-bit instance with the same windows and checks both each cycle
// against a sort-based rank model delayed by the pipeline latency.
module tb_median3x3_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  mode;
  logic [71:0] win8;
  logic [89:0] win10;
  logic        out_valid8, out_valid10;
  logic [7:0]  out_pix8;
  logic [9:0]  out_pix10;
  logic [1:0]  out_mode8, out_mode10;

  median3x3_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .win(win8), .mode(mode),
    .out_valid(out_valid8), .out_pix(out_pix8), .out_mode(out_mode8));

  median3x3_pipe #(.WIDTH(10)) u_dut10 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .win(win10), .mode(mode),
    .out_valid(out_valid10), .out_pix(out_pix10), .out_mode(out_mode10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ov  = 0;
  int cur_p [9];

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Rank by full sort of the masked window.
  function automatic int ref_rank(input int p [9], input logic [1:0] m, input int mask);
    int s [9];
    int t;
    for (int k = 0; k < 9; k++) s[k] = p[k] & mask;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    case (m)
      2'b00:   return s[4];
      2'b01:   return s[0];
      2'b10:   return s[8];
      default: return p[4] & mask;
    endcase
  endfunction

  task automatic apply(input int p [9], input logic [1:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = m;
    for (int k = 0; k < 9; k++) begin
      cur_p[k]           = p[k];
      win8[k*8 +: 8]     = 8'(p[k]);
      win10[k*10 +: 10]  = 10'(p[k]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      mode     = 2'($urandom);
      for (int k = 0; k < 9; k++) begin
        win8[k*8 +: 8]    = 8'($urandom);
        win10[k*10 +: 10] = 10'($urandom);
      end
    end
  endtask

  task automatic rand_win(input int maxv, output int p [9]);
    for (int k = 0; k < 9; k++) p[k] = int'($urandom_range(maxv, 0));
  endtask

  // Expected-output history, index 2 = window sampled two edges ago (now at the outputs).
  bit       h_vld [3];
  int       h_e8  [3];
  int       h_e10 [3];
  logic [1:0] h_md [3];
  int       hold8, hold10;
  logic [1:0] holdm;

  initial begin : cmp
    for (int i = 0; i < 3; i++) begin
      h_vld[i] = 0; h_e8[i] = 0; h_e10[i] = 0; h_md[i] = 2'b00;
    end
    hold8 = 0; hold10 = 0; holdm = 2'b00;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 3; i++) begin
          h_vld[i] = 0; h_e8[i] = 0; h_e10[i] = 0; h_md[i] = 2'b00;
        end
        hold8 = 0; hold10 = 0; holdm = 2'b00;
      end else begin
        for (int i = 2; i > 0; i--) begin
          h_vld[i] = h_vld[i-1]; h_e8[i] = h_e8[i-1];
          h_e10[i] = h_e10[i-1]; h_md[i] = h_md[i-1];
        end
        h_vld[0] = in_valid;
        h_md[0]  = mode;
        h_e8[0]  = in_valid ? ref_rank(cur_p, mode, 255) : 0;
        h_e10[0] = in_valid ? ref_rank(cur_p, mode, 1023) : 0;
        if (h_vld[2]) begin
          hold8 = h_e8[2]; hold10 = h_e10[2]; holdm = h_md[2];
        end
      end
      #1;
      chk("out_valid8",  int'(out_valid8),  int'(h_vld[2]));
      chk("out_pix8",    int'(out_pix8),    hold8);
      chk("out_mode8",   int'(out_mode8),   int'(holdm));
      chk("out_valid10", int'(out_valid10), int'(h_vld[2]));
      chk("out_pix10",   int'(out_pix10),   hold10);
      chk("out_mode10",  int'(out_mode10),  int'(holdm));
      if (out_valid8) n_ov++;
    end
  end

  initial begin : stim
    int t1 [9]   = '{7, 3, 9, 1, 5, 8, 2, 6, 4};
    int all255 [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    int one255 [9] = '{0, 0, 0, 0, 0, 0, 255, 0, 0};
    int all80 [9]  = '{128, 128, 128, 128, 128, 128, 128, 128, 128};
    int dup10 [9]  = '{1023, 1023, 0, 0, 512, 1023, 0, 512, 7};
    int alt10 [9]  = '{1023, 0, 1023, 0, 1023, 0, 1023, 0, 512};
    int rp [9];

    reset_n  = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    win8     = '0;
    win10    = '0;
    for (int k = 0; k < 9; k++) cur_p[k] = 0;

    // Pin the model against hand-computed ranks.
    chk("model_t1_med",     ref_rank(t1, 2'b00, 255), 5);
    chk("model_t1_min",     ref_rank(t1, 2'b01, 255), 1);
    chk("model_t1_max",     ref_rank(t1, 2'b10, 255), 9);
    chk("model_t1_ctr",     ref_rank(t1, 2'b11, 255), 5);
    chk("model_all255",     ref_rank(all255, 2'b00, 255), 255);
    chk("model_one255_med", ref_rank(one255, 2'b00, 255), 0);
    chk("model_one255_max", ref_rank(one255, 2'b10, 255), 255);
    chk("model_dup10_med",  ref_rank(dup10, 2'b00, 1023), 512);
    chk("model_dup10_min",  ref_rank(dup10, 2'b01, 1023), 0);
    chk("model_dup10_max",  ref_rank(dup10, 2'b10, 1023), 1023);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Single window, explicit latency check.
    apply(t1, 2'b00);
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t1_valid_at_lat", int'(out_valid8), 1);
    chk("t1_pix_at_lat",   int'(out_pix8), 5);
    chk("t1_mode_at_lat",  int'(out_mode8), 0);
    @(posedge clk);
    #2;
    chk("t1_valid_after", int'(out_valid8), 0);
    chk("t1_pix_held",    int'(out_pix8), 5);
    idle(3);

    apply(t1, 2'b01);
    apply(t1, 2'b10);
    apply(t1, 2'b11);
    idle(5);

    apply(all255, 2'b00);
    apply(one255, 2'b00);
    apply(one255, 2'b10);
    for (int m = 0; m < 4; m++) apply(all80, 2'(m));
    idle(5);

    for (int n = 0; n < 20; n++) begin
      rand_win(1023, rp);
      apply(rp, 2'($urandom));
    end
    idle(5);
    for (int n = 0; n < 20; n++) begin
      rand_win(1023, rp);
      apply(rp, 2'($urandom));
    end
    idle(5);

    // Reset with three windows in flight.
    for (int n = 0; n < 3; n++) begin
      rand_win(255, rp);
      rp[0] = 200; rp[1] = 201; rp[2] = 202;
      apply(rp, 2'b10);
    end
    @(posedge clk);
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_async_valid8", int'(out_valid8), 0);
    chk("rst_async_pix8",   int'(out_pix8), 0);
    chk("rst_async_pix10",  int'(out_pix10), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_ov = 0;
    rand_win(1023, rp);
    apply(rp, 2'b00);
    idle(6);
    chk("post_rst_results", n_ov, 1);

    apply(dup10, 2'b00);
    apply(dup10, 2'b01);
    apply(dup10, 2'b10);
    apply(dup10, 2'b11);
    apply(alt10, 2'b00);
    apply(alt10, 2'b10);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
